ascii_seven_seg_mux: RTL and testbench

- Drives a 4-digit, common-anode seven-segment display from four packed ASCII characters.
- Time-multiplexes the digits with a refresh counter and decodes ASCII to active-low segments.
- Issues a periodic one-cycle `doneWithDigit` pulse that paces the scroll buffer directly upstream (`scrolling_ascii_display`).
- Replaces the generic display stage with a cycle-parameterised, fully registered implementation.

---
 rtl/ascii_seven_seg_mux_if.sv | 22 ++
 rtl/ascii_seven_seg_mux.sv | 100 ++++++++++
 tb/tb_ascii_seven_seg_mux.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ascii_seven_seg_mux_if.sv
// Display-side bundle: packed ASCII text in, segment/anode drive
// and the scroll pacing pulse out.
interface ascii_seven_seg_mux_if;
  logic [31:0] packedAscii;
  logic [0:6]  seg;
  logic [3:0]  an;
  logic        doneWithDigit;

  modport master (
    output packedAscii,
    input  seg,
    input  an,
    input  doneWithDigit
  );

  modport slave (
    input  packedAscii,
    output seg,
    output an,
    output doneWithDigit
  );
endinterface

// File: rtl/ascii_seven_seg_mux.sv
// Four-digit common-anode ASCII display driver with refresh scan
// and a free-running hold pulse for the upstream scroll buffer.
module ascii_seven_seg_mux #(
  parameter int REFRESH_CYCLES = 50000,
  parameter int HOLD_CYCLES    = 25000000
) (
  input  logic                   clk,
  input  logic                   reset,
  ascii_seven_seg_mux_if.slave   disp
);

  localparam int RW = $clog2(REFRESH_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [RW-1:0] RLAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [HW-1:0] HLAST = HW'(HOLD_CYCLES - 1);
  localparam logic [0:6] BLANK = 7'b1111111;

  logic [31:0]   shadow_q, shadow_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [1:0]    d_q, d_d;
  logic [0:6]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          done_q, done_d;
  logic          rwrap, hwrap;
  logic [7:0]    cur_ch;

  function automatic logic [0:6] decode(input logic [7:0] c);
    case (c)
      8'h30:        decode = 7'b0000001;
      8'h31:        decode = 7'b1001111;
      8'h32:        decode = 7'b0010010;
      8'h33:        decode = 7'b0000110;
      8'h34:        decode = 7'b1001100;
      8'h35:        decode = 7'b0100100;
      8'h36:        decode = 7'b0100000;
      8'h37:        decode = 7'b0001111;
      8'h38:        decode = 7'b0000000;
      8'h39:        decode = 7'b0000100;
      8'h41, 8'h61: decode = 7'b0001000;
      8'h42, 8'h62: decode = 7'b1100000;
      8'h43, 8'h63: decode = 7'b0110001;
      8'h44, 8'h64: decode = 7'b1000010;
      8'h45, 8'h65: decode = 7'b0110000;
      8'h46, 8'h66: decode = 7'b0111000;
      8'h2D:        decode = 7'b1111110;
      default:      decode = BLANK;
    endcase
  endfunction

  always_comb begin
    cur_ch = shadow_q[31:24];
    unique case (d_q)
      2'd3: cur_ch = shadow_q[31:24];
      2'd2: cur_ch = shadow_q[23:16];
      2'd1: cur_ch = shadow_q[15:8];
      2'd0: cur_ch = shadow_q[7:0];
      default: cur_ch = shadow_q[31:24];
    endcase
  end

  // Anode and segments are built from the current digit so they
  // always switch together on the same edge.
  always_comb begin
    rwrap    = (rcnt_q == RLAST);
    hwrap    = (hcnt_q == HLAST);
    shadow_d = disp.packedAscii;
    rcnt_d   = rwrap ? '0 : rcnt_q + 1'b1;
    hcnt_d   = hwrap ? '0 : hcnt_q + 1'b1;
    d_d      = rwrap ? d_q - 2'd1 : d_q;
    done_d   = hwrap;
    an_d     = ~(4'b0001 << d_q);
    seg_d    = decode(cur_ch);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      rcnt_q   <= '0;
      hcnt_q   <= '0;
      d_q      <= 2'd3;
      seg_q    <= BLANK;
      an_q     <= 4'b1111;
      done_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      rcnt_q   <= rcnt_d;
      hcnt_q   <= hcnt_d;
      d_q      <= d_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      done_q   <= done_d;
    end
  end

  assign disp.seg           = seg_q;
  assign disp.an            = an_q;
  assign disp.doneWithDigit = done_q;

endmodule

// File: tb/tb_ascii_seven_seg_mux.sv
// Bench for ascii_seven_seg_mux: decode table, scan/pulse
// scoreboard, mid-scan update and mid-operation reset.
module tb_ascii_seven_seg_mux;
  localparam int R  = 4;
  localparam int H  = 20;
  localparam int NV = 27;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;

  ascii_seven_seg_mux_if bus ();

  ascii_seven_seg_mux #(
    .REFRESH_CYCLES(R),
    .HOLD_CYCLES(H)
  ) dut (
    .clk(clk),
    .reset(reset),
    .disp(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ch;
    logic [6:0] seg;
  } vec_t;

  typedef struct {
    int         e;
    logic [3:0] an;
    logic [6:0] seg;
    logic       done;
  } exp_t;

  vec_t vt[NV];
  exp_t sb[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [11:0] got, logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {bus.an, bus.seg, bus.doneWithDigit};
  endfunction

  function automatic logic [6:0] lut(logic [7:0] c);
    for (int i = 0; i < NV; i++)
      if (vt[i].ch == c) return vt[i].seg;
    return 7'b1111111;
  endfunction

  // Digit lit after release edge e: 3 for edges 1..R, then 2, ...
  function automatic int dig_at(int e);
    return 3 - (((e - 1) / R) % 4);
  endfunction

  function automatic logic [7:0] ch_of(logic [31:0] txt, int d);
    logic [31:0] t;
    t = txt >> (8 * d);
    return t[7:0];
  endfunction

  task automatic scan(int first, int last, logic [31:0] txt,
                      output int pulses);
    exp_t x, y;
    pulses = 0;
    for (int e = first; e <= last; e++) begin
      x.e    = e;
      x.an   = ~(4'b0001 << dig_at(e));
      x.seg  = (e == 1) ? 7'b1111111 : lut(ch_of(txt, dig_at(e)));
      x.done = (e % H == 0);
      sb.push_back(x);
      tick();
      y = sb.pop_front();
      chk($sformatf("scan e=%0d", y.e), outs(), {y.an, y.seg, y.done});
      if (bus.doneWithDigit === 1'b1) pulses++;
    end
  endtask

  task automatic do_reset(int n, logic [31:0] txt);
    bus.packedAscii = txt;
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int p;
    vt[0]  = '{8'h30, 7'b0000001};
    vt[1]  = '{8'h31, 7'b1001111};
    vt[2]  = '{8'h32, 7'b0010010};
    vt[3]  = '{8'h33, 7'b0000110};
    vt[4]  = '{8'h34, 7'b1001100};
    vt[5]  = '{8'h35, 7'b0100100};
    vt[6]  = '{8'h36, 7'b0100000};
    vt[7]  = '{8'h37, 7'b0001111};
    vt[8]  = '{8'h38, 7'b0000000};
    vt[9]  = '{8'h39, 7'b0000100};
    vt[10] = '{8'h41, 7'b0001000};
    vt[11] = '{8'h61, 7'b0001000};
    vt[12] = '{8'h42, 7'b1100000};
    vt[13] = '{8'h62, 7'b1100000};
    vt[14] = '{8'h43, 7'b0110001};
    vt[15] = '{8'h63, 7'b0110001};
    vt[16] = '{8'h44, 7'b1000010};
    vt[17] = '{8'h64, 7'b1000010};
    vt[18] = '{8'h45, 7'b0110000};
    vt[19] = '{8'h65, 7'b0110000};
    vt[20] = '{8'h46, 7'b0111000};
    vt[21] = '{8'h66, 7'b0111000};
    vt[22] = '{8'h2D, 7'b1111110};
    vt[23] = '{8'h00, 7'b1111111};
    vt[24] = '{8'h20, 7'b1111111};
    vt[25] = '{8'h3F, 7'b1111111};
    vt[26] = '{8'h47, 7'b1111111};

    // Reset values, scan order and hold pulses over 100 edges
    bus.packedAscii = 32'h31323334;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("reset c=%0d", i), outs(), {4'b1111, 7'b1111111, 1'b0});
    end
    reset = 1'b0;
    scan(1, 100, 32'h31323334, p);
    chk("pulse count 100", 12'(p), 12'd5);

    // Decode table, character placed in digit 3
    for (int i = 0; i < NV; i++) begin
      do_reset(1, {vt[i].ch, 24'h0});
      tick();
      tick();
      chk($sformatf("decode ch=%h", vt[i].ch), outs(),
          {4'b0111, vt[i].seg, 1'b0});
    end

    // Text change while digit 2 is lit
    do_reset(1, 32'h31323334);
    scan(1, 5, 32'h31323334, p);
    bus.packedAscii = 32'h38383838;
    tick();
    chk("update e6", outs(), {4'b1011, 7'b0010010, 1'b0});
    tick();
    chk("update e7", outs(), {4'b1011, 7'b0000000, 1'b0});

    // Reset at edge 37 drops the edge-40 pulse and restarts
    do_reset(1, 32'h31323334);
    scan(1, 36, 32'h31323334, p);
    chk("pulses before mid reset", 12'(p), 12'd1);
    reset = 1'b1;
    tick();
    chk("mid reset", outs(), {4'b1111, 7'b1111111, 1'b0});
    reset = 1'b0;
    scan(1, 20, 32'h31323334, p);
    chk("pulses after mid reset", 12'(p), 12'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
